// File: rtl/neuron_acc_ctrl.sv
// neuron_acc_ctrl: sequences one accumulation job through an external ALU.
// The accumulator is fed back to the ALU as operand B. Each accepted term
// loads the ALU result and decrements the term counter. The final value is
// presented on out_data until the consumer takes it.
// Optional build macro: NEURON_ACC_SAT_EN. When it is defined, an add of 1
// at the maximum positive accumulator value holds the accumulator at that
// maximum instead of letting the ALU result wrap.
module neuron_acc_ctrl #(
    parameter int alu_width = 12,
    parameter int cnt_width = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [cnt_width-1:0]        num_terms,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_bit,
    input  logic                        in_op,
    output logic                        alu_in_a_lsb,
    output logic                        alu_op,
    output logic signed [alu_width-1:0] alu_in_b,
    input  logic signed [alu_width-1:0] alu_result,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [alu_width-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic signed [alu_width-1:0] ACC_MAX = {1'b0, {(alu_width-1){1'b1}}};
    localparam logic [cnt_width-1:0]        CNT_ONE = cnt_width'(1);

    state_t                        state_q, state_d;
    logic signed [alu_width-1:0]   acc_q, acc_d;
    logic [cnt_width-1:0]          cnt_q, cnt_d;
    logic                          term_acc;
    logic                          sat_hold;

    // The ALU operands pass straight through in every state. Operand B is the
    // raw accumulator, and a negative value is left for the ALU to clamp.
    assign alu_in_a_lsb = in_bit;
    assign alu_op       = in_op;
    assign alu_in_b     = acc_q;

    // Handshake and status signals are decoded from the state alone.
    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;

    assign term_acc = in_valid && in_ready;

`ifdef NEURON_ACC_SAT_EN
    // Stop an add at the positive limit so it cannot wrap to negative.
    assign sat_hold = !in_op && in_bit && (acc_q == ACC_MAX);
`else
    assign sat_hold = 1'b0;
`endif

    // State, accumulator and counter registers. All three are cleared by the
    // asynchronous reset, which discards any job in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A start with zero terms goes straight to DONE with
    // the accumulator cleared. The last accepted term moves the FSM to DONE
    // on the same edge.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (num_terms != '0) begin
                        cnt_d   = num_terms;
                        state_d = ACCUM;
                    end else begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (term_acc) begin
                    if (!sat_hold)
                        acc_d = alu_result;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// tb_neuron_acc_ctrl: directed checks of neuron_acc_ctrl with a behavioural
// ReLU +/- ALU model. The counter is made wide enough for the 2048-term
// saturation/wrap job.
module tb_neuron_acc_ctrl;

    localparam int AW = 12;
    localparam int CW = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CW-1:0]        num_terms;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_bit;
    logic                 in_op;
    logic                 alu_in_a_lsb;
    logic                 alu_op;
    logic signed [AW-1:0] alu_in_b;
    logic signed [AW-1:0] alu_result;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_data;

    int total = 0;
    int bad   = 0;

    neuron_acc_ctrl #(.alu_width(AW), .cnt_width(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_terms    (num_terms),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bit       (in_bit),
        .in_op        (in_op),
        .alu_in_a_lsb (alu_in_a_lsb),
        .alu_op       (alu_op),
        .alu_in_b     (alu_in_b),
        .alu_result   (alu_result),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    // External ALU: ReLU(B) plus or minus the magnitude bit, wrapping in AW bits.
    logic signed [AW-1:0] relu_b;
    always_comb begin
        relu_b     = alu_in_b[AW-1] ? '0 : alu_in_b;
        alu_result = alu_op ? (relu_b - AW'(alu_in_a_lsb)) : (relu_b + AW'(alu_in_a_lsb));
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic term(input logic op, input logic b);
        in_valid = 1'b1; in_op = op; in_bit = b;
        step();
        in_valid = 1'b0;
    endtask

    logic signed [AW-1:0] sat_exp;

    initial begin
        rst = 1'b1; start = 1'b0; num_terms = '0; in_valid = 1'b0;
        in_bit = 1'b0; in_op = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        in_bit = 1'b1; in_op = 1'b1; #1;
        chk("pass_lsb", alu_in_a_lsb, 1);
        chk("pass_op", alu_op, 1);
        in_bit = 1'b0; in_op = 1'b0;
        rst = 1'b0;

        // Job 1: four back-to-back adds.
        start = 1'b1; num_terms = 4; out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("j1_ready", in_ready, 1);
        chk("j1_busy", busy, 1);
        term(0, 1); term(0, 1); term(0, 1);
        chk("j1_acc3", alu_in_b, 3);
        chk("j1_nvalid3", out_valid, 0);
        term(0, 1);
        chk("j1_ovalid", out_valid, 1);
        chk("j1_odata", out_data, 4);
        chk("j1_ready_done", in_ready, 0);
        step();
        chk("j1_idle_ov", out_valid, 0);
        chk("j1_idle_busy", busy, 0);

        // Job 2: subtract from 0, then the ReLU clamp, then an add.
        start = 1'b1; num_terms = 3;
        step();
        start = 1'b0;
        term(1, 1);
        chk("j2_acc_m1", alu_in_b, -1);
        term(1, 1);
        chk("j2_acc_clamp", alu_in_b, -1);
        term(0, 1);
        chk("j2_ovalid", out_valid, 1);
        chk("j2_odata", out_data, 1);
        step();

        // Job 3: zero terms, with the result held while out_ready is low.
        out_ready = 1'b0;
        start = 1'b1; num_terms = 0;
        step();
        start = 1'b0;
        chk("j3_ovalid", out_valid, 1);
        chk("j3_odata", out_data, 0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; num_terms = 5;
            step();
            chk("j3_hold_ov", out_valid, 1);
            chk("j3_hold_od", out_data, 0);
            chk("j3_hold_rdy", in_ready, 0);
        end
        start = 1'b0; out_ready = 1'b1;
        step();
        chk("j3_idle", busy, 0);

        // Job 4: terms with gaps, then a reset in the middle of the job.
        start = 1'b1; num_terms = 5;
        step();
        start = 1'b0;
        term(0, 1); step();
        chk("j4_gap_hold", alu_in_b, 1);
        term(0, 1); step(); step();
        chk("j4_gap_hold2", alu_in_b, 2);
        term(0, 1);
        chk("j4_acc3", alu_in_b, 3);
        rst = 1'b1; #1;
        chk("j4_rst_ready", in_ready, 0);
        chk("j4_rst_busy", busy, 0);
        chk("j4_rst_ov", out_valid, 0);
        chk("j4_rst_od", out_data, 0);
        #1 rst = 1'b0;
        start = 1'b1; num_terms = 1;
        step();
        start = 1'b0;
        chk("j4b_ready", in_ready, 1);
        term(0, 1);
        chk("j4b_ovalid", out_valid, 1);
        chk("j4b_odata", out_data, 1);
        step();

        // Job 5: reach the positive limit, then add once more.
        start = 1'b1; num_terms = 2048;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_op = 1'b0; in_bit = 1'b1;
        for (int i = 0; i < 2047; i++) step();
        in_valid = 1'b0;
        chk("j5_max", alu_in_b, 2047);
        chk("j5_nvalid", out_valid, 0);
        term(0, 1);
`ifdef NEURON_ACC_SAT_EN
        sat_exp = 12'sd2047;
`else
        sat_exp = -12'sd2048;
`endif
        chk("j5_ovalid", out_valid, 1);
        chk("j5_odata", out_data, sat_exp);
        step();
        chk("j5_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
